sdiv_unit: RTL and testbench

- Multi-cycle signed integer divider peripheral on the xtop core's external side.
- Takes dividend D and divisor d, produces quotient and remainder with a start/done handshake.
- Results are written back by the controller into the register file.
- Radix-2 restoring iteration on magnitudes, followed by a sign-fix cycle; latency is constant.

---
 rtl/sdiv_unit_pkg.sv | 13 +
 rtl/sdiv_step.sv | 32 +++
 rtl/sdiv_unit.sv | 161 ++++++++++++++++
 tb/tb_sdiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sdiv_unit_pkg.sv
// Shared definitions for the signed divider: FSM state encodings and default widths.
package sdiv_unit_pkg;

  localparam int SDIV_DATA_W_DEF = 8;
  localparam int SDIV_CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    SDIV_IDLE = 2'd0,
    SDIV_ITER = 2'd1,
    SDIV_SIGN = 2'd2
  } sdiv_state_e;

endpackage

// File: rtl/sdiv_step.sv
// One radix-2 restoring step: shift {prem, qreg} left, trial-subtract the divisor magnitude.
module sdiv_step #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] prem_i,
  input  logic [DATA_W-1:0] qreg_i,
  input  logic [DATA_W-1:0] dmag_i,
  output logic [DATA_W-1:0] prem_o,
  output logic [DATA_W-1:0] qreg_o
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] trial;
  logic              unused_hi;

  assign shifted = {prem_i, qreg_i[DATA_W-1]};
  // Extra headroom bit so the borrow is visible even when shifted exceeds 2**DATA_W.
  assign trial   = {1'b0, shifted} - {2'b00, dmag_i};

  // The top bits only carry information when dividing by zero, whose result is overridden.
  assign unused_hi = ^{trial[DATA_W], shifted[DATA_W]};

  always_comb begin
    prem_o = shifted[DATA_W-1:0];
    qreg_o = {qreg_i[DATA_W-2:0], 1'b0};
    if (!trial[DATA_W+1]) begin
      prem_o = trial[DATA_W-1:0];
      qreg_o = {qreg_i[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/sdiv_unit.sv
// Multi-cycle signed divider: restoring iteration on magnitudes, then one sign-fix cycle.
// Define SDIV_DIVZERO_TRAP_EN to add the sticky dz_trap output.
module sdiv_unit
  import sdiv_unit_pkg::*;
#(
  parameter int DATA_W = SDIV_DATA_W_DEF,
  parameter int CNT_W  = SDIV_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
`ifdef SDIV_DIVZERO_TRAP_EN
  output logic              dz_trap,
`endif
  output logic              div_zero,
  output logic              ovf
);

  localparam logic [DATA_W-1:0] MinInt = {1'b1, {(DATA_W-1){1'b0}}};

  sdiv_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prem_q, prem_d, qreg_q, qreg_d, dmag_q, dmag_d, dvd_q, dvd_d;
  logic              negQuot_q, negQuot_d, negRem_q, negRem_d;
  logic              zero_q, zero_d, ovfHit_q, ovfHit_d;
  logic [DATA_W-1:0] quot_q, quot_d, rem_q, rem_d;
  logic              done_q, done_d, divZero_q, divZero_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] stepPrem, stepQreg;

  sdiv_step #(.DATA_W(DATA_W)) u_step (
    .prem_i (prem_q),
    .qreg_i (qreg_q),
    .dmag_i (dmag_q),
    .prem_o (stepPrem),
    .qreg_o (stepQreg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SDIV_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SDIV_IDLE: if (start) state_d = SDIV_ITER;
      SDIV_ITER: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = SDIV_SIGN;
      SDIV_SIGN: state_d = SDIV_IDLE;
      default:   state_d = SDIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != SDIV_IDLE);
  end

  always_comb begin
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    qreg_d    = qreg_q;
    dmag_d    = dmag_q;
    dvd_d     = dvd_q;
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;
    zero_d    = zero_q;
    ovfHit_d  = ovfHit_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divZero_d = divZero_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      SDIV_IDLE: begin
        if (start) begin
          // Unsigned view of the negated MIN_INT is exactly its magnitude, so nothing is lost.
          qreg_d    = dividend[DATA_W-1] ? -dividend : dividend;
          dmag_d    = divisor[DATA_W-1] ? -divisor : divisor;
          dvd_d     = dividend;
          negQuot_d = dividend[DATA_W-1] ^ divisor[DATA_W-1];
          negRem_d  = dividend[DATA_W-1];
          zero_d    = (divisor == '0);
          ovfHit_d  = (dividend == MinInt) && (divisor == '1);
          prem_d    = '0;
          cnt_d     = '0;
        end
      end
      SDIV_ITER: begin
        prem_d = stepPrem;
        qreg_d = stepQreg;
        cnt_d  = cnt_q + 1'b1;
      end
      SDIV_SIGN: begin
        quot_d    = zero_q ? '1 : (negQuot_q ? -qreg_q : qreg_q);
        rem_d     = zero_q ? dvd_q : (negRem_q ? -prem_q : prem_q);
        divZero_d = zero_q;
        ovf_d     = ovfHit_q;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      prem_q    <= '0;
      qreg_q    <= '0;
      dmag_q    <= '0;
      dvd_q     <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      zero_q    <= 1'b0;
      ovfHit_q  <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      qreg_q    <= qreg_d;
      dmag_q    <= dmag_d;
      dvd_q     <= dvd_d;
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
      zero_q    <= zero_d;
      ovfHit_q  <= ovfHit_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divZero_q <= divZero_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = divZero_q;
  assign ovf       = ovf_q;

`ifdef SDIV_DIVZERO_TRAP_EN
  logic dzTrap_q;

  // Sticky until reset so the core can OR it into its trap line at leisure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 dzTrap_q <= 1'b0;
    else if (state_q == SDIV_SIGN && zero_q)  dzTrap_q <= 1'b1;
  end

  assign dz_trap = dzTrap_q;
`endif

endmodule

// File: tb/tb_sdiv_unit.sv
// Scoreboard bench for sdiv_unit: directed vectors queue expected results, a monitor checks each done.
module tb_sdiv_unit;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         startEdge;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_zero, ovf;
  logic [7:0] quotient, remainder;
`ifdef SDIV_DIVZERO_TRAP_EN
  logic       dz_trap;
`endif

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   doneCyc = 0;

  sdiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef SDIV_DIVZERO_TRAP_EN
    .dz_trap   (dz_trap),
`endif
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every done must match the oldest queued expectation and arrive 9 edges after its start edge.
  always @(negedge clk) begin
    if (done) begin
      doneCyc = cyc;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("quotient", {24'd0, quotient}, {24'd0, e.q});
        checkOutput("remainder", {24'd0, remainder}, {24'd0, e.r});
        checkOutput("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ov});
        checkOutput("latency", cyc, e.startEdge + 9);
        checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_timeout: got busy=1, expected 0 (cycle %0d)", cyc);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] s, input logic [7:0] q,
                               input logic [7:0] r, input logic dz, input logic ov);
    exp_t e;
    @(negedge clk);
    waitIdle();
    dividend = d;
    divisor  = s;
    start    = 1'b1;
    e = '{q: q, r: r, dz: dz, ov: ov, startEdge: cyc + 1};
    expQ.push_back(e);
    @(negedge clk);
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    // A mid-operation request with different operands must leave the running op untouched.
    dividend = 8'h09;
    divisor  = 8'h03;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'h5A;
    divisor  = 8'hA5;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_quotient", {24'd0, quotient}, 32'd0);
    checkOutput("reset_remainder", {24'd0, remainder}, 32'd0);
    checkOutput("reset_div_zero", {31'd0, div_zero}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b1;

    applyStimulus(8'd5, 8'd2, 8'h02, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0);
    applyStimulus(8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
    applyStimulus(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0);
    applyStimulus(8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1'b0);
    applyStimulus(8'd3, 8'd1, 8'h03, 8'h00, 1'b0, 1'b0);
    waitIdle();
`ifdef SDIV_DIVZERO_TRAP_EN
    checkOutput("dz_trap_sticky", {31'd0, dz_trap}, 32'd1);
`endif

    // Held start: the second op is sampled on the edge after the first done, so dones are 10 apart.
    begin
      exp_t e;
      int firstDone;
      int n;
      @(negedge clk);
      waitIdle();
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      e = '{q: 8'd14, r: 8'd2, dz: 1'b0, ov: 1'b0, startEdge: cyc + 1};
      expQ.push_back(e);
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 40);
      firstDone = cyc;
      e.startEdge = cyc + 1;
      expQ.push_back(e);
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 40);
      start = 1'b0;
      checkOutput("back_to_back_gap", cyc - firstDone, 32'd10);
    end

    // Abort mid-iteration: reset must clear outputs immediately with no done afterwards.
    @(negedge clk);
    waitIdle();
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_quotient", {24'd0, quotient}, 32'd0);
    checkOutput("abort_remainder", {24'd0, remainder}, 32'd0);
`ifdef SDIV_DIVZERO_TRAP_EN
    checkOutput("abort_dz_trap", {31'd0, dz_trap}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(8'hF7, 8'd4, 8'hFE, 8'hFF, 1'b0, 1'b0);

    begin
      int n = 0;
      while (expQ.size() != 0 && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (expQ.size() != 0) begin
        total++;
        bad++;
        $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", expQ.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
